// File: rtl/load_store_queue_if.sv
// Shared entry type and the dispatch / memory-stage / D-cache bundle for the
// load/store queue.
package lsq_pkg;
  localparam int ROB_W  = 5;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic              is_store;
    logic [ROB_W-1:0]  tag;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] value;
  } lsq_entry_t;
endpackage

interface load_store_queue_if #(
  parameter int LSQ_SIZE = 16
) ();
  localparam int PTR_W = $clog2(LSQ_SIZE);

  logic                        alloc_valid;
  logic                        alloc_is_store;
  logic [lsq_pkg::ROB_W-1:0]   alloc_tag;
  logic                        alloc_ready;
  logic [PTR_W:0]              alloc_id;
  logic [PTR_W:0]              upd_ptr;
  lsq_pkg::lsq_entry_t         upd_entry;
  logic                        commit_valid;
  logic [lsq_pkg::ROB_W-1:0]   commit_tag;
  logic                        flush;
  logic                        store_req;
  logic [lsq_pkg::ADDR_W-1:0]  store_addr;
  logic [lsq_pkg::DATA_W-1:0]  store_data;
  logic                        store_ack;
  lsq_pkg::lsq_entry_t         lsq [LSQ_SIZE];
  int                          lsq_head;
  int                          lsq_tail;
  logic [PTR_W:0]              lsq_count;
  logic                        commit_err;

  modport slave (
    input  alloc_valid, alloc_is_store, alloc_tag, upd_ptr, upd_entry,
           commit_valid, commit_tag, flush, store_ack,
    output alloc_ready, alloc_id, store_req, store_addr, store_data,
           lsq, lsq_head, lsq_tail, lsq_count, commit_err
  );

  modport master (
    output alloc_valid, alloc_is_store, alloc_tag, upd_ptr, upd_entry,
           commit_valid, commit_tag, flush, store_ack,
    input  alloc_ready, alloc_id, store_req, store_addr, store_data,
           lsq, lsq_head, lsq_tail, lsq_count, commit_err
  );
endinterface

// File: rtl/load_store_queue.sv
// Circular in-order load/store queue: allocate at tail, resolve via memory-stage
// updates, retire at head on ROB commit; committed stores drain to the D-cache.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for a commit that matches a valid, ready head entry
//   S_DRAIN | head is a committed store; store_req held until store_ack
module load_store_queue #(
  parameter int LSQ_SIZE = 16
) (
  input logic               i_clk,
  input logic               i_reset,
  load_store_queue_if.slave bus
);
  localparam int PTR_W = $clog2(LSQ_SIZE);

  typedef enum logic [0:0] {S_IDLE, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  lsq_pkg::lsq_entry_t r_lsq [LSQ_SIZE];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [PTR_W:0]      r_count;
  logic                r_store_req;
  logic                r_commit_err;

  lsq_pkg::lsq_entry_t w_head_entry;
  logic                w_alloc_ready;
  logic                w_alloc;
  logic                w_upd;
  logic [PTR_W-1:0]    w_upd_idx;
  logic                w_match;
  logic                w_retire;
  logic                w_err;
  logic                w_unused_upd;

  assign w_head_entry  = r_lsq[r_head];
  assign w_alloc_ready = (r_count < (PTR_W+1)'(LSQ_SIZE));
  assign w_alloc       = bus.alloc_valid & w_alloc_ready & ~bus.flush;
  assign w_upd_idx     = PTR_W'(bus.upd_ptr - (PTR_W+1)'(1));
  assign w_upd         = (bus.upd_ptr != '0) & r_lsq[w_upd_idx].valid & ~bus.flush;
  assign w_match       = w_head_entry.valid & w_head_entry.ready &
                         (bus.commit_tag == w_head_entry.tag);
  // Only ready/address/value of an update image are meaningful.
  assign w_unused_upd  = ^{bus.upd_entry.valid, bus.upd_entry.is_store, bus.upd_entry.tag};

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.commit_valid && !bus.flush) begin
          if (w_match) begin
            if (w_head_entry.is_store) w_state_nxt = S_DRAIN;
            else                       w_retire    = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.store_ack) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end
        if (bus.commit_valid) w_err = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_store_req  <= 1'b0;
      r_commit_err <= 1'b0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      for (int i = 0; i < LSQ_SIZE; i++) r_lsq[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_store_req  <= (w_state_nxt == S_DRAIN);
      r_commit_err <= r_commit_err | w_err;

      if (bus.flush) begin
        // A draining store is already committed, so it survives the squash.
        for (int i = 0; i < LSQ_SIZE; i++) begin
          if (!(r_state == S_DRAIN && PTR_W'(i) == r_head)) r_lsq[i] <= '0;
        end
        if (r_state == S_DRAIN) begin
          r_tail  <= r_head + PTR_W'(1);
          r_count <= w_retire ? '0 : (PTR_W+1)'(1);
        end else begin
          r_head  <= '0;
          r_tail  <= '0;
          r_count <= '0;
        end
      end else begin
        if (w_upd) begin
          r_lsq[w_upd_idx].ready   <= bus.upd_entry.ready;
          r_lsq[w_upd_idx].address <= bus.upd_entry.address;
          r_lsq[w_upd_idx].value   <= bus.upd_entry.value;
        end
        if (w_alloc) begin
          r_lsq[r_tail] <= '{valid: 1'b1, ready: 1'b0, is_store: bus.alloc_is_store,
                             tag: bus.alloc_tag, address: '0, value: '0};
          r_tail        <= r_tail + PTR_W'(1);
        end
        case ({w_alloc, w_retire})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end

      // Placed last so retirement overrides an update to the same entry.
      if (w_retire) begin
        r_lsq[r_head] <= '0;
        r_head        <= r_head + PTR_W'(1);
      end
    end
  end

  assign bus.alloc_ready = w_alloc_ready;
  assign bus.alloc_id    = {1'b0, r_tail} + (PTR_W+1)'(1);
  assign bus.store_req   = r_store_req;
  assign bus.store_addr  = r_store_req ? w_head_entry.address : '0;
  assign bus.store_data  = r_store_req ? w_head_entry.value   : '0;
  assign bus.lsq         = r_lsq;
  assign bus.lsq_head    = int'(r_head);
  assign bus.lsq_tail    = int'(r_tail);
  assign bus.lsq_count   = r_count;
  assign bus.commit_err  = r_commit_err;
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: stimulus pushes expected values into
// queues, a negedge monitor pops and compares them against the DUT.
module tb_load_store_queue;
  localparam int N = 16;

  localparam int S_COUNT = 0, S_HEAD = 1, S_TAIL = 2, S_ARDY = 3, S_AID = 4,
                 S_SREQ = 5, S_ERR = 6, S_EVALID = 7, S_EREADY = 8, S_ETAG = 9,
                 S_EVALUE = 10, S_SADDR = 11;

  typedef struct { string name; int sel; int idx; longint exp; } chk_t;
  typedef struct { longint addr; longint data; } st_t;

  logic clk = 1'b0;
  logic reset;
  chk_t q_chk[$];
  st_t  q_st[$];
  int   n_checks = 0;
  int   n_errors = 0;

  load_store_queue_if #(.LSQ_SIZE(N)) bus ();
  load_store_queue #(.LSQ_SIZE(N)) dut (.i_clk(clk), .i_reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic longint get_val(int sel, int idx);
    case (sel)
      S_COUNT:  return longint'(bus.lsq_count);
      S_HEAD:   return longint'(bus.lsq_head);
      S_TAIL:   return longint'(bus.lsq_tail);
      S_ARDY:   return longint'(bus.alloc_ready);
      S_AID:    return longint'(bus.alloc_id);
      S_SREQ:   return longint'(bus.store_req);
      S_ERR:    return longint'(bus.commit_err);
      S_EVALID: return longint'(bus.lsq[idx].valid);
      S_EREADY: return longint'(bus.lsq[idx].ready);
      S_ETAG:   return longint'(bus.lsq[idx].tag);
      S_EVALUE: return longint'(bus.lsq[idx].value);
      S_SADDR:  return longint'(bus.store_addr);
      default:  return -1;
    endcase
  endfunction

  task automatic expect_val(string name, int sel, int idx, longint exp);
    q_chk.push_back('{name: name, sel: sel, idx: idx, exp: exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_alloc(bit is_store, int tag);
    bus.alloc_valid    = 1'b1;
    bus.alloc_is_store = is_store;
    bus.alloc_tag      = 5'(tag);
    tick();
    bus.alloc_valid    = 1'b0;
  endtask

  task automatic do_upd(int ptr, longint addr, longint val);
    bus.upd_ptr           = 5'(ptr);
    bus.upd_entry         = '0;
    bus.upd_entry.ready   = 1'b1;
    bus.upd_entry.address = 32'(addr);
    bus.upd_entry.value   = 32'(val);
    tick();
    bus.upd_ptr           = '0;
  endtask

  task automatic do_commit(int tag);
    bus.commit_valid = 1'b1;
    bus.commit_tag   = 5'(tag);
    tick();
    bus.commit_valid = 1'b0;
  endtask

  // Monitor: compares queued state expectations and every accepted store.
  initial begin
    chk_t   c;
    st_t    s;
    longint act;
    forever begin
      @(negedge clk);
      while (q_chk.size() > 0) begin
        c   = q_chk.pop_front();
        act = get_val(c.sel, c.idx);
        n_checks++;
        if (act !== c.exp) begin
          n_errors++;
          $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
        end
      end
      if (bus.store_req === 1'b1 && bus.store_ack === 1'b1) begin
        n_checks++;
        if (q_st.size() == 0) begin
          n_errors++;
          $display("FAIL store_unexpected: got addr %0h with no store expected", bus.store_addr);
        end else begin
          s = q_st.pop_front();
          if (longint'(bus.store_addr) != s.addr || longint'(bus.store_data) != s.data) begin
            n_errors++;
            $display("FAIL store_beat: got %0h/%0h expected %0h/%0h",
                     bus.store_addr, bus.store_data, s.addr, s.data);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.alloc_valid = 1'b0; bus.alloc_is_store = 1'b0; bus.alloc_tag = '0;
    bus.upd_ptr = '0; bus.upd_entry = '0; bus.commit_valid = 1'b0;
    bus.commit_tag = '0; bus.flush = 1'b0; bus.store_ack = 1'b0;

    // 1: reset values, fill to full, overflow alloc ignored
    do_reset();
    expect_val("rst_count", S_COUNT, 0, 0);
    expect_val("rst_head", S_HEAD, 0, 0);
    expect_val("rst_tail", S_TAIL, 0, 0);
    expect_val("rst_ready", S_ARDY, 0, 1);
    expect_val("rst_id", S_AID, 0, 1);
    expect_val("rst_sreq", S_SREQ, 0, 0);
    expect_val("rst_err", S_ERR, 0, 0);
    expect_val("rst_e5_valid", S_EVALID, 5, 0);
    for (int i = 0; i < N; i++) do_alloc(1'b0, i);
    expect_val("full_count", S_COUNT, 0, 16);
    expect_val("full_ready", S_ARDY, 0, 0);
    expect_val("full_tail", S_TAIL, 0, 0);
    expect_val("full_e5_tag", S_ETAG, 5, 5);
    expect_val("full_e15_tag", S_ETAG, 15, 15);
    do_alloc(1'b0, 20);
    expect_val("ovf_count", S_COUNT, 0, 16);
    expect_val("ovf_tail", S_TAIL, 0, 0);
    expect_val("ovf_e0_tag", S_ETAG, 0, 0);

    // 2: load alloc, update, commit; then alloc+retire in one cycle
    do_reset();
    do_alloc(1'b0, 3);
    expect_val("ld_count", S_COUNT, 0, 1);
    expect_val("ld_id", S_AID, 0, 2);
    expect_val("ld_ready0", S_EREADY, 0, 0);
    do_upd(1, 'h100, 'hDEAD);
    expect_val("upd_value", S_EVALUE, 0, 'hDEAD);
    expect_val("upd_ready", S_EREADY, 0, 1);
    expect_val("upd_tag_kept", S_ETAG, 0, 3);
    do_upd(5, 'h500, 'h77);
    expect_val("upd_invalid_value", S_EVALUE, 4, 0);
    expect_val("upd_invalid_valid", S_EVALID, 4, 0);
    do_commit(3);
    expect_val("ret_valid", S_EVALID, 0, 0);
    expect_val("ret_value", S_EVALUE, 0, 0);
    expect_val("ret_head", S_HEAD, 0, 1);
    expect_val("ret_count", S_COUNT, 0, 0);
    expect_val("ret_err", S_ERR, 0, 0);
    do_alloc(1'b0, 8);
    do_upd(2, 'h0, 'h8);
    bus.alloc_valid = 1'b1; bus.alloc_tag = 5'd9;
    bus.commit_valid = 1'b1; bus.commit_tag = 5'd8;
    tick();
    bus.alloc_valid = 1'b0; bus.commit_valid = 1'b0;
    expect_val("sim_count", S_COUNT, 0, 1);
    expect_val("sim_head", S_HEAD, 0, 2);
    expect_val("sim_tail", S_TAIL, 0, 3);

    // 3: store drain with ack held low for three cycles
    do_reset();
    do_alloc(1'b1, 7);
    do_upd(1, 'h2000, 'hCAFE);
    do_commit(7);
    q_st.push_back('{addr: 'h2000, data: 'hCAFE});
    expect_val("drain_req_c1", S_SREQ, 0, 1);
    expect_val("drain_addr_c1", S_SADDR, 0, 'h2000);
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_val("drain_req_hold", S_SREQ, 0, 1);
      expect_val("drain_addr_hold", S_SADDR, 0, 'h2000);
      expect_val("drain_head_hold", S_HEAD, 0, 0);
    end
    bus.store_ack = 1'b1;
    tick();
    bus.store_ack = 1'b0;
    expect_val("ack_req", S_SREQ, 0, 0);
    expect_val("ack_head", S_HEAD, 0, 1);
    expect_val("ack_count", S_COUNT, 0, 0);

    // 4: full queue, retire and alloc same cycle -> alloc refused, then wraps
    do_reset();
    for (int i = 0; i < N; i++) do_alloc(1'b0, i);
    do_upd(1, 'h10, 'h1);
    bus.alloc_valid = 1'b1; bus.alloc_tag = 5'd20;
    bus.commit_valid = 1'b1; bus.commit_tag = 5'd0;
    tick();
    bus.alloc_valid = 1'b0; bus.commit_valid = 1'b0;
    expect_val("fr_count", S_COUNT, 0, 15);
    expect_val("fr_head", S_HEAD, 0, 1);
    expect_val("fr_tail", S_TAIL, 0, 0);
    expect_val("fr_ready", S_ARDY, 0, 1);
    expect_val("fr_e0_valid", S_EVALID, 0, 0);
    do_alloc(1'b0, 21);
    expect_val("wrap_e0_tag", S_ETAG, 0, 21);
    expect_val("wrap_e0_valid", S_EVALID, 0, 1);
    expect_val("wrap_tail", S_TAIL, 0, 1);
    expect_val("wrap_count", S_COUNT, 0, 16);

    // 5: flush while draining keeps only the head store
    do_reset();
    do_alloc(1'b1, 4);
    for (int i = 10; i < 14; i++) do_alloc(1'b0, i);
    do_upd(1, 'h40, 'h55);
    do_commit(4);
    q_st.push_back('{addr: 'h40, data: 'h55});
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    expect_val("fl_count", S_COUNT, 0, 1);
    expect_val("fl_tail", S_TAIL, 0, 1);
    expect_val("fl_head", S_HEAD, 0, 0);
    expect_val("fl_e0_valid", S_EVALID, 0, 1);
    expect_val("fl_e1_valid", S_EVALID, 1, 0);
    expect_val("fl_e4_valid", S_EVALID, 4, 0);
    expect_val("fl_sreq", S_SREQ, 0, 1);
    bus.store_ack = 1'b1;
    tick();
    bus.store_ack = 1'b0;
    expect_val("fl_ack_count", S_COUNT, 0, 0);
    expect_val("fl_ack_head", S_HEAD, 0, 1);
    expect_val("fl_ack_sreq", S_SREQ, 0, 0);

    // 6: commit mismatches set the sticky error without moving head
    do_reset();
    do_alloc(1'b0, 4);
    do_commit(9);
    expect_val("err_tag", S_ERR, 0, 1);
    expect_val("err_head", S_HEAD, 0, 0);
    expect_val("err_count", S_COUNT, 0, 1);
    tick();
    expect_val("err_sticky", S_ERR, 0, 1);
    do_reset();
    expect_val("err_rst", S_ERR, 0, 0);
    do_alloc(1'b0, 4);
    do_commit(4);
    expect_val("err_notready", S_ERR, 0, 1);
    expect_val("err_nr_valid", S_EVALID, 0, 1);

    for (int i = 0; i < 20 && q_chk.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (q_chk.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending checks expected 0", q_chk.size());
    end
    n_checks++;
    if (q_st.size() != 0) begin
      n_errors++;
      $display("FAIL store_missing: got %0d unretired stores expected 0", q_st.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
